// File: rtl/mul_shift8_pkg.sv
// Shared types and constants for the mul_shift8 sequential multiplier.
package mul_shift8_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_t;

    localparam int MUL_DEFAULT_WIDTH = 8;
    localparam int MUL_CNT_W         = $clog2(MUL_DEFAULT_WIDTH + 1);

    // Step-counter width for an arbitrary operand width (must hold the value WIDTH).
    function automatic int mul_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_shift8.sv
// Shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH cycles.
// Define MUL_SHIFT8_SIGNED_EN to honour sgn (two's complement operands).
//
// state | meaning
// IDLE  | waiting for start; product/zero hold the last result
// RUN   | one add/shift step per edge until the counter reaches 0
module mul_shift8
    import mul_shift8_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   sgn,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product,
    output logic                   zero
);

    localparam int CNT_W = mul_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);

    mul_state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;

    logic               accept;
    logic               finish;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_nx;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] result;

`ifdef MUL_SHIFT8_SIGNED_EN
    // Magnitudes are WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
    always_comb begin
        mag_a  = (sgn && a[WIDTH-1]) ? (~a + ONE_W) : a;
        mag_b  = (sgn && b[WIDTH-1]) ? (~b + ONE_W) : b;
        neg_nx = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    // sgn is accepted on the port but has no effect in the unsigned-only build.
    always_comb begin
        mag_a  = a;
        mag_b  = b;
        neg_nx = sgn & 1'b0;
    end
`endif

    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (acc[0]) begin
            acc_step = {upper_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
        result = neg_q ? (~acc_step + ONE_P) : acc_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_ONE) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            zero    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mcand <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
                cnt   <= CNT_LOAD;
                neg_q <= neg_nx;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt - CNT_ONE;
                if (finish) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    product <= result;
                    zero    <= (result == '0);
                end
            end
        end
    end

endmodule
